// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake bundle between issue, muldiv_unit and writeback
interface muldiv_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;
  modport slave (
    input  i_valid, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_ready,
    output o_ready, o_valid, o_result, o_rd_addr
  );
  modport master (
    output i_valid, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_ready,
    input  o_ready, o_valid, o_result, o_rd_addr
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with valid/ready request and result handshakes
module muldiv_unit #(
  parameter bit FAST_MUL = 1'b0
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic        neg;
  logic [4:0]  rd;
  logic [31:0] b;
  logic [63:0] p;
  logic        in_div, sa, sb, div0, ovf;
  logic [31:0] mag_a, mag_b, special;
  logic [32:0] sum, shifted, diff;
  logic [63:0] mul_step, div_step, fast_prod, p_next, pf;
  logic [31:0] q, r, res;
  assign in_div  = bus.i_funct3[2];
  assign sa      = bus.i_rs1_data[31] & (in_div ? ~bus.i_funct3[0] : bus.i_funct3 != 3'b011);
  assign sb      = bus.i_rs2_data[31] & (in_div ? ~bus.i_funct3[0] : ~bus.i_funct3[1]);
  assign mag_a   = sa ? -bus.i_rs1_data : bus.i_rs1_data;
  assign mag_b   = sb ? -bus.i_rs2_data : bus.i_rs2_data;
  assign div0    = in_div && bus.i_rs2_data == 32'd0;
  assign ovf     = in_div && !bus.i_funct3[0] && bus.i_rs1_data == 32'h8000_0000 && bus.i_rs2_data == 32'hFFFF_FFFF;
  assign special = div0 ? (bus.i_funct3[1] ? bus.i_rs1_data : 32'hFFFF_FFFF)
                        : (bus.i_funct3[1] ? 32'd0 : 32'h8000_0000);
  // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  assign sum       = {1'b0, p[63:32]} + (p[0] ? {1'b0, b} : 33'd0);
  assign mul_step  = {sum, p[31:1]};
  assign shifted   = {p[63:32], p[31]};
  assign diff      = shifted - {1'b0, b};
  assign div_step  = diff[32] ? {shifted[31:0], p[30:0], 1'b0} : {diff[31:0], p[30:0], 1'b1};
  assign fast_prod = 64'(b) * 64'(p[31:0]);
  assign p_next    = op[2] ? div_step : (FAST_MUL ? fast_prod : mul_step);
  assign pf        = neg ? -p_next : p_next;
  assign q         = p_next[31:0];
  assign r         = p_next[63:32];
  assign res       = op[2] ? (op[1] ? (neg ? -r : r) : (neg ? -q : q))
                           : (op[1:0] == 2'b00 ? pf[31:0] : pf[63:32]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 5'd0;
      bus.o_valid   <= 1'b0;
      bus.o_ready   <= 1'b1;
      bus.o_result  <= 32'd0;
      bus.o_rd_addr <= 5'd0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          op          <= bus.i_funct3;
          neg         <= bus.i_funct3 == 3'b110 ? sa : sa ^ sb;
          rd          <= bus.i_rd_addr;
          bus.o_ready <= 1'b0;
          if (div0 || ovf) begin
            bus.o_result  <= special;
            bus.o_rd_addr <= bus.i_rd_addr;
            bus.o_valid   <= 1'b1;
            state         <= DONE;
          end else begin
            b     <= in_div ? mag_b : mag_a;
            p     <= {32'd0, in_div ? mag_a : mag_b};
            cnt   <= (FAST_MUL && !in_div) ? 5'd0 : 5'd31;
            state <= BUSY;
          end
        end
        BUSY: begin
          p   <= p_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            bus.o_result  <= res;
            bus.o_rd_addr <= rd;
            bus.o_valid   <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: if (bus.i_ready) begin
          bus.o_valid <= 1'b0;
          bus.o_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors on iterative and fast-multiply units against an arithmetic model
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  muldiv_if b0 ();
  muldiv_if b1 ();
  logic        sel = 1'b0, valid = 1'b0, wb_ready = 1'b0, armed = 1'b0;
  logic [2:0]  f = 3'd0;
  logic [31:0] a = 32'd0, bb = 32'd0, exp_res = 32'd0;
  logic [4:0]  rd = 5'd0, exp_rd = 5'd0;
  int checks = 0, errors = 0;
  assign b0.i_valid = valid & ~sel;
  assign b1.i_valid = valid & sel;
  assign b0.i_funct3 = f;
  assign b1.i_funct3 = f;
  assign b0.i_rs1_data = a;
  assign b1.i_rs1_data = a;
  assign b0.i_rs2_data = bb;
  assign b1.i_rs2_data = bb;
  assign b0.i_rd_addr = rd;
  assign b1.i_rd_addr = rd;
  assign b0.i_ready = wb_ready;
  assign b1.i_ready = wb_ready;
  logic        ov, ordy;
  logic [31:0] ores;
  logic [4:0]  ord;
  assign ov   = sel ? b1.o_valid : b0.o_valid;
  assign ordy = sel ? b1.o_ready : b0.o_ready;
  assign ores = sel ? b1.o_result : b0.o_result;
  assign ord  = sel ? b1.o_rd_addr : b0.o_rd_addr;
  muldiv_unit #(.FAST_MUL(1'b0)) dut   (.clk(clk), .rst(rst), .bus(b0));
  muldiv_unit #(.FAST_MUL(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(b1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x)), sy = longint'($signed(y));
    longint ux = longint'({32'd0, x}), uy = longint'({32'd0, y});
    logic [63:0] pr;
    if (!fn[2]) begin
      pr = fn == 3'd3 ? ux * uy : (fn == 3'd2 ? sx * uy : sx * sy);
      return fn == 3'd0 ? pr[31:0] : pr[63:32];
    end
    if (y == 32'd0) return fn[1] ? x : 32'hFFFF_FFFF;
    case (fn[1:0])
      2'b00:   pr = 64'(sx / sy);
      2'b01:   pr = 64'(ux / uy);
      2'b10:   pr = 64'(sx % sy);
      default: pr = 64'(ux % uy);
    endcase
    return pr[31:0];
  endfunction
  function automatic int exp_lat(input logic s, input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    if (!fn[2]) return s ? 1 : 32;
    if (y == 32'd0 || (!fn[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 0;
    return 32;
  endfunction
  // results must hold steady for as long as o_valid is up; any unrequested o_valid is an error
  always @(negedge clk) if (ov) begin
    if (!armed) chk("spurious_valid", 32'(ov), 32'd0);
    else begin
      chk("result", ores, exp_res);
      chk("rd_addr", 32'(ord), 32'(exp_rd));
    end
  end
  task automatic do_op(input logic s, input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] lit, input int hold);
    int n;
    chk("model_pin", model(fn, x, y), lit);
    @(negedge clk);
    sel = s;
    exp_res = model(fn, x, y);
    exp_rd = r;
    f = fn; a = x; bb = y; rd = r; valid = 1'b1;
    n = 0;
    while (!ordy && n < 100) begin @(negedge clk); n++; end
    if (!ordy) chk("accept_timeout", 32'(ordy), 32'd1);
    @(posedge clk);
    armed = 1'b1;
    #1 valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov && n < 100) begin
      chk("busy_ready", 32'(ordy), 32'd0);
      valid = 1'($urandom_range(0, 1));
      a = $urandom;
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat(s, fn, x, y)));
    repeat (hold) begin
      chk("bp_ready", 32'(ordy), 32'd0);
      valid = 1'b1;
      f = 3'($urandom);
      a = $urandom;
      bb = $urandom;
      @(negedge clk);
    end
    valid = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("done_valid", 32'(ov), 32'd0);
    chk("done_ready", 32'(ordy), 32'd1);
    armed = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      #1;
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_ready", 32'(ordy), 32'd1);
      chk("rst_result", ores, 32'd0);
      chk("rst_rd", 32'(ord), 32'd0);
    end
    rst = 1'b0;
    do_op(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 0);
    do_op(1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0);
    do_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0);
    do_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0);
    do_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 5);
    do_op(1'b0, 3'b111, 32'd100, 32'd7, 5'd0, 32'd2, 0);
    do_op(1'b0, 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 0);
    do_op(1'b0, 3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 3);
    do_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
    do_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0);
    do_op(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFEB, 0);
    do_op(1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd14, 32'h4000_0000, 0);
    do_op(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 2);
    do_op(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 3'b101, 32'd100, 32'd7, 5'd17, 32'd14, 0);
    @(negedge clk);
    sel = 1'b0; f = 3'b100; a = 32'd1000; bb = 32'd3; rd = 5'd18; valid = 1'b1;
    @(posedge clk);
    armed = 1'b1;
    #1 valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(ov), 32'd0);
    chk("midrst_ready", 32'(ordy), 32'd1);
    armed = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle_ready", 32'(ordy), 32'd1);
    do_op(1'b0, 3'b101, 32'd100, 32'd7, 5'd19, 32'd14, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file.
- Consumes the two read-port operands plus the destination index on a valid/ready handshake.
- Runs a shift-add multiply or a restoring divide over multiple cycles.
- Holds the 32-bit result and rd index for the writeback stage until writeback accepts it.

Parameters:
- FAST_MUL, default 0: 0 = multiply is iterative, 32 iteration cycles. 1 = multiply is computed with a single-cycle 64-bit product, 1 iteration cycle. Divide is always iterative.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- i_valid  input  1  operation request from decode/issue
- o_ready  output  1  unit can accept a request this cycle
- i_funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1_data  input  32  operand A (register-file read port 1)
- i_rs2_data  input  32  operand B (register-file read port 2)
- i_rd_addr  input  5  destination register index, passed through
- o_valid  output  1  result available
- i_ready  input  1  writeback accepts the result
- o_result  output  32  result data, for the register-file write-data input
- o_rd_addr  output  5  destination index, for the register-file write-address input

Behaviour:
- States:
  - IDLE: o_ready=1, o_valid=0.
  - BUSY: o_ready=0, o_valid=0.
  - DONE: o_ready=0, o_valid=1.
- Reset: state IDLE, o_valid=0, o_ready=1, o_result=0, o_rd_addr=0, iteration counter=0. Reset mid-operation discards the operation; the unit is IDLE on the cycle after the reset edge.
- Accept: occurs when i_valid && o_ready at a rising edge.
  - funct3, both operands and rd_addr are latched. Inputs are ignored at all other times.
  - Signed ops (MUL*, DIV, REM per the RV32M spec) convert operands to magnitudes; the result sign is latched for fix-up.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- IDLE→BUSY on accept, with counter loaded to 31. Exception: the divide special cases below.
- BUSY: one iteration per cycle; counter decrements.
  - Multiply: shift-add over a 64-bit unsigned accumulator.
  - Divide: restoring, one quotient bit per cycle over a 32-bit remainder.
  - BUSY→DONE at the edge where counter==0. With FAST_MUL=1, multiply spends exactly one BUSY cycle.
- Final fix-up, applied at BUSY→DONE:
  - Conditional two's-complement negation of the 64-bit product, quotient or remainder.
  - Quotient takes sign(A) xor sign(B); remainder takes sign(A).
  - Selection: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
- Latency:
  - Iterative ops: o_valid rises 33 cycles after the accept edge.
  - FAST_MUL multiply: 2 cycles.
  - Special cases: 1 cycle.
- Divide special cases skip BUSY; the unit goes IDLE→DONE directly:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend unchanged.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- DONE:
  - o_result and o_rd_addr stay stable while o_valid && !i_ready.
  - DONE→IDLE on the edge where i_ready=1. o_valid drops and o_ready rises on the next cycle.
  - No back-to-back accept in the handshake cycle, because o_ready=0 in DONE.
- i_valid may toggle freely while the unit is not IDLE; the requester holds the request until o_ready.
- rd_addr 0 is passed through unchanged; discarding writes to x0 is the register file's job.
- o_result and o_rd_addr hold the last value after returning to IDLE; only o_valid qualifies them.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3), FAST_MUL=0 → o_result=0xFFFFFFEB, o_rd_addr echoes 5'd9, o_valid rises exactly 33 cycles after accept.
- Upper halves:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - FAST_MUL=1 gives the same values with o_valid 2 cycles after accept.
- Division:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - REM 7/-2 → 1.
- Special cases, each with o_valid 1 cycle after accept and no BUSY cycles:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure:
  - Hold i_ready=0 for 5 cycles after o_valid: o_valid, o_result and o_rd_addr stay stable; o_ready=0; i_valid pulses are ignored.
  - Raise i_ready: o_ready=1 next cycle, and the next op is accepted and correct.
- Reset during the 10th BUSY cycle of a DIV: o_valid=0 and o_ready=1 on the next cycle, with no spurious o_valid. A subsequent DIVU 100/7 returns 14.
